findmax_job_arbiter: RTL

- Shares one findMax engine (start/n/startaddr in, done/max out) among NREQ requesters.
- Accepts jobs round-robin, launches the engine, waits for completion, and returns the maximum to the owning requester.
- Sits between the requester blocks and the engine instance, one level above the engine in the hierarchy.

---
 rtl/findmax_job_arbiter.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/findmax_job_arbiter.sv
// Round-robin job arbiter that shares one findMax engine among NREQ requesters.
// It grants one job at a time, runs the engine, and returns the max (or an error) to the owner.
module findmax_job_arbiter #(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned NW        = 8,
  parameter int unsigned AW        = 16,
  parameter int unsigned DW        = 16,
  parameter int unsigned START_LEN = 2,
  parameter int unsigned TIMEOUT   = 1023
) (
  input  logic               mclk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*NW-1:0] req_n,
  input  logic [NREQ*AW-1:0] req_addr,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [DW-1:0]      rsp_max,
  output logic               rsp_err,
  output logic               busy,
  output logic               eng_start,
  output logic [NW-1:0]      eng_n,
  output logic [AW-1:0]      eng_startaddr,
  input  logic               eng_done,
  input  logic [DW-1:0]      eng_max
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned LW = (START_LEN > 1) ? $clog2(START_LEN) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StLaunch, StWait, StResp} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   win_q, win_d;
  logic [IW-1:0]   rr_q, rr_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NW-1:0]   eng_n_q, eng_n_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [LW-1:0]   lcnt_q, lcnt_d;
  logic [TW-1:0]   tcnt_q, tcnt_d;
  logic [DW-1:0]   rsp_max_q, rsp_max_d;
  logic            rsp_err_q, rsp_err_d;
  logic            done_q;

  logic [NW-1:0]   n_arr [NREQ];
  logic [AW-1:0]   a_arr [NREQ];
  logic [IW-1:0]   pick_idx;
  logic [IW-1:0]   cand;
  logic            pick_hit;

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign n_arr[g] = req_n[g*NW +: NW];
    assign a_arr[g] = req_addr[g*AW +: AW];
  end

  // First requesting index at or after the round-robin pointer, wrapping.
  always_comb begin
    pick_idx = rr_q;
    pick_hit = 1'b0;
    cand     = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = IW'((32'(rr_q) + k) % NREQ);
      if (!pick_hit && req[cand]) begin
        pick_idx = cand;
        pick_hit = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    rr_d      = rr_q;
    gnt_d     = '0;
    eng_n_d   = eng_n_q;
    addr_d    = addr_q;
    lcnt_d    = lcnt_q;
    tcnt_d    = tcnt_q;
    rsp_max_d = rsp_max_q;
    rsp_err_d = rsp_err_q;
    unique case (state_q)
      StIdle: begin
        if (|req) begin
          win_d   = pick_idx;
          gnt_d   = NREQ'(1) << pick_idx;
          eng_n_d = n_arr[pick_idx];
          addr_d  = a_arr[pick_idx];
          lcnt_d  = '0;
          tcnt_d  = '0;
          state_d = StLaunch;
        end
      end
      StLaunch: begin
        // A zero-length job is rejected on the latched count before the engine is started.
        if (eng_n_q == '0) begin
          rsp_max_d = '0;
          rsp_err_d = 1'b1;
          state_d   = StResp;
        end else if (lcnt_q == LW'(START_LEN - 1)) begin
          tcnt_d  = '0;
          state_d = StWait;
        end else begin
          lcnt_d = lcnt_q + 1'b1;
        end
      end
      StWait: begin
        // Only a fresh rising edge counts; a done level left over from the last job is ignored.
        if (eng_done && !done_q) begin
          rsp_max_d = eng_max;
          rsp_err_d = 1'b0;
          state_d   = StResp;
        end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
          rsp_max_d = '0;
          rsp_err_d = 1'b1;
          state_d   = StResp;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      StResp: begin
        rr_d    = (win_q == IW'(NREQ - 1)) ? '0 : win_q + 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      win_q     <= '0;
      rr_q      <= '0;
      gnt_q     <= '0;
      eng_n_q   <= '0;
      addr_q    <= '0;
      lcnt_q    <= '0;
      tcnt_q    <= '0;
      rsp_max_q <= '0;
      rsp_err_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      rr_q      <= rr_d;
      gnt_q     <= gnt_d;
      eng_n_q   <= eng_n_d;
      addr_q    <= addr_d;
      lcnt_q    <= lcnt_d;
      tcnt_q    <= tcnt_d;
      rsp_max_q <= rsp_max_d;
      rsp_err_q <= rsp_err_d;
      done_q    <= eng_done;
    end
  end

  assign gnt           = gnt_q;
  assign busy          = (state_q != StIdle);
  assign eng_start     = (state_q == StLaunch) && (eng_n_q != '0);
  assign eng_n         = eng_n_q;
  assign eng_startaddr = addr_q;
  assign rsp_valid     = (state_q == StResp) ? (NREQ'(1) << win_q) : '0;
  assign rsp_max       = rsp_max_q;
  assign rsp_err       = rsp_err_q;

endmodule
